// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_MEM_LAT = 1;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - grant select between CPU and DMA; MEM_ARB_RR_EN selects round-robin ties
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_owner,
    output logic grant
);

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not own the previous grant wins.
    always_comb begin
        if (cpu_req && dma_req) begin
            grant = other_owner(owner_t'(last_owner));
        end else if (dma_req) begin
            grant = OWN_DMA;
        end else begin
            grant = OWN_CPU;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        if (dma_req && !cpu_req) begin
            grant = OWN_DMA;
        end else begin
            grant = OWN_CPU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-access-at-a-time arbiter for the shared CPU/DMA memory; tie policy via MEM_ARB_RR_EN
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_t        state;
    state_t        state_next;
    owner_t        owner;
    owner_t        last_owner;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          sel_grant;
    logic          cnt_done;

    mem_arb_sel u_sel (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_owner (last_owner),
        .grant      (sel_grant)
    );

    assign cnt_done = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE, so the owner's held req in DONE is never re-granted early.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        mem_en     = 1'b0;
        cpu_ack    = 1'b0;
        dma_ack    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ack    = (owner == OWN_CPU);
                dma_ack    = (owner == OWN_DMA);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            if (grant) begin
                owner      <= owner_t'(sel_grant);
                last_owner <= owner_t'(sel_grant);
                if (sel_grant == OWN_DMA) begin
                    mem_we    <= dma_we;
                    mem_addr  <= dma_addr;
                    mem_wdata <= dma_wdata;
                end else begin
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end

            if (state == ISSUE) begin
                cnt <= CNT_LOAD;
            end else if ((state == WAIT) && !cnt_done) begin
                cnt <= cnt - CW'(1);
            end

            // Writes leave the owner's read register untouched.
            if ((state == WAIT) && cnt_done && !mem_we) begin
                if (owner == OWN_CPU) begin
                    cpu_rdata <= mem_rdata;
                end else begin
                    dma_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
